space_wire_timer_bank: RTL and testbench

Multi-channel, run-time-programmable timeout generator for the SpaceWire link layer. It replaces the fixed two-timer arrangement (6.4 us / 12.8 us) with `C_CHANNELS` independent counters. Each counter has its own terminal count, one-shot or periodic mode, and start/stop controls. The bank sits beside the link state machine and also serves disconnect-timeout, time-code-watchdog and credit-timeout users.

---
 rtl/space_wire_timer_bank.sv | 100 ++++++++++
 tb/tb_space_wire_timer_bank.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/space_wire_timer_bank.sv
// rtl/space_wire_timer_bank.sv - bank of independent programmable timeout channels for the SpaceWire link layer
module space_wire_timer_bank #(
  parameter int C_CHANNELS    = 4,
  parameter int C_COUNT_WIDTH = 12
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [C_CHANNELS-1:0]                i_start,
  input  logic [C_CHANNELS-1:0]                i_stop,
  input  logic [C_CHANNELS-1:0]                i_periodic,
  input  logic [C_CHANNELS*C_COUNT_WIDTH-1:0]  i_period,
  output logic [C_CHANNELS-1:0]                o_expire,
  output logic [C_CHANNELS-1:0]                o_running,
  output logic [C_CHANNELS-1:0]                o_done,
  output logic [C_CHANNELS-1:0]                o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = C_COUNT_WIDTH'(1);

  for (genvar n = 0; n < C_CHANNELS; n++) begin : g_ch
    state_t                    state_q, state_d;
    logic [C_COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [C_COUNT_WIDTH-1:0]  period_q, period_d;
    logic                      mode_q, mode_d;
    logic                      expire_q, expire_d;
    logic                      running_q, done_q;
    logic                      cfg_err_q, cfg_err_d;
    logic [C_COUNT_WIDTH-1:0]  period_in;

    assign period_in = i_period[n*C_COUNT_WIDTH +: C_COUNT_WIDTH];

    // Next-state: stop beats start beats normal counting; a zero-period start is flagged and otherwise ignored
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      mode_d    = mode_q;
      expire_d  = 1'b0;
      cfg_err_d = 1'b0;
      if (i_stop[n]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (i_start[n] && (period_in != '0)) begin
        state_d  = ST_RUN;
        cnt_d    = CNT_ONE;
        period_d = period_in;
        mode_d   = i_periodic[n];
      end else begin
        cfg_err_d = i_start[n];
        if (state_q == ST_RUN) begin
          if (cnt_q == period_q) begin
            expire_d = 1'b1;
            if (mode_q) begin
              cnt_d = CNT_ONE;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
    end

    // State and registered outputs; reset aborts any count immediately
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        period_q  <= '0;
        mode_q    <= 1'b0;
        expire_q  <= 1'b0;
        running_q <= 1'b0;
        done_q    <= 1'b0;
        cfg_err_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        period_q  <= period_d;
        mode_q    <= mode_d;
        expire_q  <= expire_d;
        running_q <= (state_d == ST_RUN);
        done_q    <= (state_d == ST_DONE);
        cfg_err_q <= cfg_err_d;
      end
    end

    assign o_expire[n]  = expire_q;
    assign o_running[n] = running_q;
    assign o_done[n]    = done_q;
    assign o_cfg_err[n] = cfg_err_q;
  end

endmodule

// File: tb/tb_space_wire_timer_bank.sv
// tb/tb_space_wire_timer_bank.sv - self-checking bench for space_wire_timer_bank
module tb_space_wire_timer_bank;

  localparam int NCH = 4;
  localparam int W   = 12;

  logic              i_clk;
  logic              i_reset;
  logic [NCH-1:0]    i_start;
  logic [NCH-1:0]    i_stop;
  logic [NCH-1:0]    i_periodic;
  logic [NCH*W-1:0]  i_period;
  logic [NCH-1:0]    o_expire;
  logic [NCH-1:0]    o_running;
  logic [NCH-1:0]    o_done;
  logic [NCH-1:0]    o_cfg_err;

  space_wire_timer_bank #(.C_CHANNELS(NCH), .C_COUNT_WIDTH(W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_periodic (i_periodic),
    .i_period   (i_period),
    .o_expire   (o_expire),
    .o_running  (o_running),
    .o_done     (o_done),
    .o_cfg_err  (o_cfg_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model: each channel remembers when it was started, with what
  // period and mode; expiry is derived from elapsed edges since the start.
  bit          m_active [NCH];
  bit          m_mode   [NCH];
  int          m_k      [NCH];
  int          m_p      [NCH];
  logic [NCH-1:0] m_exp, m_run, m_done, m_cfg;

  typedef struct {
    bit start;
    bit stop;
    bit periodic;
    int period;
    bit e_exp;
    bit e_run;
    bit e_done;
    bit e_cfg;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, edge_n, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int n = 0; n < NCH; n++) begin
      m_active[n] = 0;
      m_mode[n]   = 0;
      m_k[n]      = 0;
      m_p[n]      = 0;
    end
    m_exp  = '0;
    m_run  = '0;
    m_done = '0;
    m_cfg  = '0;
  endfunction

  function automatic void model_edge();
    int pn;
    int el;
    for (int n = 0; n < NCH; n++) begin
      pn = int'(i_period[n*W +: W]);
      m_exp[n] = 1'b0;
      m_cfg[n] = 1'b0;
      if (i_stop[n]) begin
        m_active[n] = 0;
        m_done[n]   = 1'b0;
      end else if (i_start[n] && pn != 0) begin
        m_active[n] = 1;
        m_k[n]      = edge_n;
        m_p[n]      = pn;
        m_mode[n]   = i_periodic[n];
        m_done[n]   = 1'b0;
      end else begin
        m_cfg[n] = i_start[n];
        if (m_active[n]) begin
          el = edge_n - m_k[n];
          if (m_mode[n]) begin
            if (el % m_p[n] == 0) m_exp[n] = 1'b1;
          end else if (el == m_p[n]) begin
            m_exp[n]    = 1'b1;
            m_active[n] = 0;
            m_done[n]   = 1'b1;
          end
        end
      end
      m_run[n] = m_active[n];
    end
  endfunction

  task automatic compare_all();
    chk("model_expire",  32'(o_expire),  32'(m_exp));
    chk("model_running", 32'(o_running), 32'(m_run));
    chk("model_done",    32'(o_done),    32'(m_done));
    chk("model_cfg_err", 32'(o_cfg_err), 32'(m_cfg));
  endtask

  // One rising edge: model sees the same sampled inputs, outputs compared 1 time unit later
  task automatic tick();
    @(posedge i_clk);
    edge_n++;
    if (i_reset) model_clear();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic set_ch(input int ch, input bit st, input bit sp, input bit per, input int p);
    i_start[ch]          = st;
    i_stop[ch]           = sp;
    i_periodic[ch]       = per;
    i_period[ch*W +: W]  = W'(p);
  endtask

  task automatic clear_ctrl();
    i_start = '0;
    i_stop  = '0;
  endtask

  task automatic stop_all();
    i_stop = '1;
    tick();
    clear_ctrl();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=running expected=finished", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int npulse;
    int rem;

    tbl[0]  = '{1, 0, 0, 3, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 7, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 9, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 3, 1, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 3, 0, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 1, 2, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 2, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 2, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 2, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 2, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 0, 2, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 0, 1, 0};
    tbl[14] = '{1, 1, 0, 4, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 4, 0, 0, 0, 0};

    i_reset    = 1'b1;
    i_start    = '0;
    i_stop     = '0;
    i_periodic = '0;
    i_period   = '0;
    model_clear();
    repeat (3) tick();
    i_reset = 1'b0;
    chk("reset_expire",  32'(o_expire),  32'h0);
    chk("reset_running", 32'(o_running), 32'h0);
    chk("reset_done",    32'(o_done),    32'h0);
    chk("reset_cfg_err", 32'(o_cfg_err), 32'h0);

    // Short table-driven sequence on channel 0
    for (int i = 0; i < 16; i++) begin
      set_ch(0, tbl[i].start, tbl[i].stop, tbl[i].periodic, tbl[i].period);
      tick();
      chk($sformatf("tbl%0d_expire", i),  32'(o_expire[0]),  32'(tbl[i].e_exp));
      chk($sformatf("tbl%0d_running", i), 32'(o_running[0]), 32'(tbl[i].e_run));
      chk($sformatf("tbl%0d_done", i),    32'(o_done[0]),    32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_cfg_err", i), 32'(o_cfg_err[0]), 32'(tbl[i].e_cfg));
    end
    clear_ctrl();
    stop_all();

    // One-shot ch0, P=320, start at relative edge 10
    s = edge_n;
    run_to(s + 9);
    set_ch(0, 1, 0, 0, 320);
    tick();
    clear_ctrl();
    chk("os_running_start", 32'(o_running[0]), 32'h1);
    run_to(s + 329);
    chk("os_expire_early",  32'(o_expire[0]),  32'h0);
    chk("os_running_329",   32'(o_running[0]), 32'h1);
    tick();
    chk("os_expire_330",    32'(o_expire[0]),  32'h1);
    chk("os_done_330",      32'(o_done[0]),    32'h1);
    chk("os_running_330",   32'(o_running[0]), 32'h0);
    run_to(s + 340);
    chk("os_done_held",     32'(o_done[0]),    32'h1);
    chk("os_expire_once",   32'(o_expire[0]),  32'h0);
    stop_all();
    chk("os_done_stop",     32'(o_done[0]),    32'h0);

    // Periodic ch1, P=1280, stopped at relative edge 3000
    s = edge_n + 1;
    set_ch(1, 1, 0, 1, 1280);
    tick();
    clear_ctrl();
    npulse = 0;
    while (edge_n < s + 2999) begin
      tick();
      if (o_expire[1]) npulse++;
      if (edge_n == s + 1280) chk("per_expire_1280", 32'(o_expire[1]), 32'h1);
      if (edge_n == s + 2560) chk("per_expire_2560", 32'(o_expire[1]), 32'h1);
    end
    i_stop[1] = 1'b1;
    tick();
    clear_ctrl();
    chk("per_running_stop", 32'(o_running[1]), 32'h0);
    while (edge_n < s + 4000) begin
      tick();
      if (o_expire[1]) npulse++;
    end
    chk("per_pulse_count", 32'(npulse), 32'd2);

    // Retrigger ch2: P=100 at 0, P=50 at 60, single expiry at 110
    s = edge_n + 1;
    set_ch(2, 1, 0, 0, 100);
    tick();
    clear_ctrl();
    run_to(s + 59);
    set_ch(2, 1, 0, 0, 50);
    tick();
    clear_ctrl();
    npulse = 0;
    while (edge_n < s + 130) begin
      tick();
      if (o_expire[2]) npulse++;
      if (edge_n == s + 100) chk("rt_no_expire_100", 32'(o_expire[2]), 32'h0);
      if (edge_n == s + 110) chk("rt_expire_110",    32'(o_expire[2]), 32'h1);
    end
    chk("rt_pulse_count", 32'(npulse), 32'd1);
    stop_all();

    // Priority ch3: stop and start together on the would-be expiry edge
    s = edge_n + 1;
    set_ch(3, 1, 0, 0, 5);
    tick();
    clear_ctrl();
    run_to(s + 4);
    set_ch(3, 1, 1, 0, 5);
    tick();
    clear_ctrl();
    chk("pri_no_expire",  32'(o_expire[3]),  32'h0);
    chk("pri_idle",       32'(o_running[3]), 32'h0);
    chk("pri_not_done",   32'(o_done[3]),    32'h0);
    set_ch(3, 1, 0, 0, 0);
    tick();
    clear_ctrl();
    chk("zero_cfg_err",   32'(o_cfg_err[3]), 32'h1);
    chk("zero_running",   32'(o_running[3]), 32'h0);
    tick();
    chk("zero_cfg_clear", 32'(o_cfg_err[3]), 32'h0);

    // Independence and boundaries: P=1,2,4095,4095(periodic) on one edge
    s = edge_n + 1;
    set_ch(0, 1, 0, 0, 1);
    set_ch(1, 1, 0, 0, 2);
    set_ch(2, 1, 0, 0, 4095);
    set_ch(3, 1, 0, 1, 4095);
    tick();
    clear_ctrl();
    tick();
    chk("ind_ch0_expire", 32'(o_expire), 32'h1);
    tick();
    chk("ind_ch1_expire", 32'(o_expire), 32'h2);
    run_to(s + 4095);
    chk("ind_ch23_expire", 32'(o_expire), 32'hc);
    chk("ind_done_mask",   32'(o_done),   32'h7);
    run_to(s + 8189);
    chk("ind_ch3_not_yet", 32'(o_expire[3]), 32'h0);
    tick();
    chk("ind_ch3_8190",    32'(o_expire[3]), 32'h1);
    chk("ind_ch3_running", 32'(o_running[3]), 32'h1);
    stop_all();

    // Asynchronous reset while channels count
    set_ch(0, 1, 0, 1, 200);
    set_ch(1, 1, 0, 0, 60);
    set_ch(2, 1, 0, 1, 1);
    tick();
    clear_ctrl();
    repeat (50) tick();
    #2;
    i_reset = 1'b1;
    model_clear();
    #1;
    chk("arst_expire",  32'(o_expire),  32'h0);
    chk("arst_running", 32'(o_running), 32'h0);
    chk("arst_done",    32'(o_done),    32'h0);
    #2;
    i_reset = 1'b0;
    npulse = 0;
    repeat (600) begin
      tick();
      if (o_expire != '0) npulse++;
    end
    chk("arst_no_expire", 32'(npulse), 32'd0);

    // Randomized traffic against the elapsed-time model
    for (int i = 0; i < 2000; i++) begin
      for (int n = 0; n < NCH; n++) begin
        i_start[n]    = ($urandom_range(0, 19) == 0);
        i_stop[n]     = ($urandom_range(0, 39) == 0);
        i_periodic[n] = $urandom_range(0, 1);
        rem = $urandom_range(0, 9);
        if (rem == 0) i_period[n*W +: W] = '0;
        else if (rem == 1) i_period[n*W +: W] = W'(4095);
        else i_period[n*W +: W] = W'($urandom_range(1, 24));
      end
      tick();
    end
    clear_ctrl();
    stop_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
